// File: rtl/diff_accum_pkg.sv
// Shared constants and types for the windowed difference accumulator and its neighbouring DSP stages.
package diff_accum_pkg;

  localparam int DSP_DW           = 16;
  localparam int DEFAULT_LOG2_WIN = 3;

  localparam logic signed [DSP_DW-1:0] SAT_MAX = 16'sh7FFF;
  localparam logic signed [DSP_DW-1:0] SAT_MIN = 16'sh8000;

  // Output side view: ACC while no result is held, PEND while one waits to be taken.
  typedef enum logic {
    ST_ACC  = 1'b0,
    ST_PEND = 1'b1
  } state_t;

endpackage

// File: rtl/diff_accum_if.sv
// Sample input and result output handshakes of the windowed accumulator.
interface diff_accum_if
  import diff_accum_pkg::*;
#(
  parameter int DW = DSP_DW
);

  logic                 din_valid;
  logic                 din_ready;
  logic signed [DW-1:0] din;

  logic                 dout_valid;
  logic                 dout_ready;
  logic signed [DW-1:0] dout_sum;
  logic signed [DW-1:0] dout_mean;
  logic                 dout_ovf;

  modport slave (
    input  din_valid, din, dout_ready,
    output din_ready, dout_valid, dout_sum, dout_mean, dout_ovf
  );

  modport master (
    output din_valid, din, dout_ready,
    input  din_ready, dout_valid, dout_sum, dout_mean, dout_ovf
  );

endinterface

// File: rtl/sat_narrow.sv
// Combinational signed saturating narrowing from IW to OW bits; requires IW > OW.
module sat_narrow #(
  parameter int IW = 19,
  parameter int OW = 16
) (
  input  logic signed [IW-1:0] din,
  output logic signed [OW-1:0] dout,
  output logic                 ovf
);

  localparam logic signed [IW-1:0] MAX_V = {{(IW-OW+1){1'b0}}, {(OW-1){1'b1}}};
  localparam logic signed [IW-1:0] MIN_V = {{(IW-OW+1){1'b1}}, {(OW-1){1'b0}}};

  function automatic logic signed [OW-1:0] sat(input logic signed [IW-1:0] x);
    if (x > MAX_V)      return MAX_V[OW-1:0];
    else if (x < MIN_V) return MIN_V[OW-1:0];
    else                return x[OW-1:0];
  endfunction

  assign ovf  = (din > MAX_V) | (din < MIN_V);
  assign dout = sat(din);

endmodule

// File: rtl/diff_accum.sv
// Sums 2**LOG2_WIN accepted signed samples and presents saturated sum, floor mean and overflow per window.
module diff_accum
  import diff_accum_pkg::*;
#(
  parameter int DW       = DSP_DW,
  parameter int LOG2_WIN = DEFAULT_LOG2_WIN
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  diff_accum_if.slave bus
);

  localparam int AW = DW + LOG2_WIN;

  logic signed [AW-1:0]  acc_q, acc_d;
  logic [LOG2_WIN-1:0]   cnt_q, cnt_d;
  logic signed [DW-1:0]  din_m;
  logic signed [AW-1:0]  din_sx;
  logic signed [AW-1:0]  tot;
  logic signed [DW-1:0]  sum_sat, mean_w;
  logic                  ovf_w;
  logic signed [DW-1:0]  sum_q, mean_q;
  logic                  ovf_q;
  state_t                state_q;
  logic                  acc_fire, last, final_fire, take;

  assign bus.din_ready = ~clr & ((state_q == ST_ACC) | bus.dout_ready);
  assign acc_fire      = bus.din_valid & bus.din_ready;
  assign last          = &cnt_q;
  assign final_fire    = acc_fire & last;
  assign take          = (state_q == ST_PEND) & bus.dout_ready;

  // Gate din so an idle (possibly unknown) bus never reaches the adder.
  assign din_m  = bus.din_valid ? bus.din : '0;
  assign din_sx = {{LOG2_WIN{din_m[DW-1]}}, din_m};
  assign tot    = acc_q + din_sx;
  assign mean_w = DW'(tot >>> LOG2_WIN);

  sat_narrow #(.IW(AW), .OW(DW)) u_sat (
    .din  (tot),
    .dout (sum_sat),
    .ovf  (ovf_w)
  );

  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    if (clr) begin
      acc_d = '0;
      cnt_d = '0;
    end else if (acc_fire) begin
      if (last) begin
        acc_d = '0;
        cnt_d = '0;
      end else begin
        acc_d = tot;
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
    end
  end

  // A final accept in the same cycle as a take reloads the result, keeping windows back to back.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_ACC;
      sum_q   <= '0;
      mean_q  <= '0;
      ovf_q   <= 1'b0;
    end else if (clr) begin
      state_q <= ST_ACC;
    end else if (final_fire) begin
      state_q <= ST_PEND;
      sum_q   <= sum_sat;
      mean_q  <= mean_w;
      ovf_q   <= ovf_w;
    end else if (take) begin
      state_q <= ST_ACC;
    end
  end

  assign bus.dout_valid = (state_q == ST_PEND);
  assign bus.dout_sum   = sum_q;
  assign bus.dout_mean  = mean_q;
  assign bus.dout_ovf   = ovf_q;

endmodule

// File: tb/tb_diff_accum.sv
// Scoreboard bench for diff_accum: a window-level reference model queues expected results, a monitor checks them.
module tb_diff_accum;
  import diff_accum_pkg::*;

  localparam int DW       = 16;
  localparam int LOG2_WIN = 3;
  localparam int WIN      = 1 << LOG2_WIN;

  typedef struct {
    int sum;
    int mean;
    int ovf;
  } exp_t;

  logic clk;
  logic rst;
  logic clr;

  diff_accum_if #(.DW(DW)) bus ();

  diff_accum #(.DW(DW), .LOG2_WIN(LOG2_WIN)) dut (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t exp_q[$];
  int   win_q[$];
  bit   m_pend = 1'b0;
  bit   m_fire = 1'b0;

  function automatic void chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic int floor_div(input int a, input int b);
    int q;
    q = a / b;
    if ((a % b != 0) && (a < 0)) q = q - 1;
    return q;
  endfunction

  function automatic exp_t window_result();
    exp_t r;
    int   tot;
    tot = 0;
    foreach (win_q[i]) tot += win_q[i];
    r.ovf  = ((tot > int'(SAT_MAX)) || (tot < int'(SAT_MIN))) ? 1 : 0;
    r.sum  = (tot > int'(SAT_MAX)) ? int'(SAT_MAX) : (tot < int'(SAT_MIN)) ? int'(SAT_MIN) : tot;
    r.mean = floor_div(tot, WIN);
    return r;
  endfunction

  function automatic void model_reset();
    m_pend = 1'b0;
    m_fire = 1'b0;
    win_q.delete();
    exp_q.delete();
  endfunction

  // Reference model: acceptance and window completion derived from the handshake rules alone.
  always @(posedge clk) begin
    if (rst) begin
      bit rdy;
      bit take;
      rdy    = !clr && (!m_pend || bus.dout_ready);
      take   = m_pend && bus.dout_ready;
      m_fire = bus.din_valid && rdy;
      if (clr) begin
        if (m_pend && !bus.dout_ready && exp_q.size() > 0) void'(exp_q.pop_back());
        m_pend = 1'b0;
        win_q.delete();
      end else begin
        if (take) m_pend = 1'b0;
        if (m_fire) begin
          win_q.push_back(int'(bus.din));
          if (win_q.size() == WIN) begin
            exp_q.push_back(window_result());
            win_q.delete();
            m_pend = 1'b1;
          end
        end
      end
    end
  end

  // Monitor: compares handshake outputs and any presented result against the scoreboard.
  always @(negedge clk) begin
    if (rst) begin
      chk("din_ready", int'(bus.din_ready), int'(!clr && (!m_pend || bus.dout_ready)));
      chk("dout_valid", int'(bus.dout_valid), int'(m_pend));
      if (bus.dout_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_result", 1, 0);
        end else begin
          chk("dout_sum", int'(bus.dout_sum), exp_q[0].sum);
          chk("dout_mean", int'(bus.dout_mean), exp_q[0].mean);
          chk("dout_ovf", int'(bus.dout_ovf), exp_q[0].ovf);
          if (bus.dout_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic send(input int v);
    int n;
    n = 0;
    bus.din_valid = 1'b1;
    bus.din       = DW'(v);
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!m_fire && n < 200);
    if (!m_fire) chk("send_timeout", 0, 1);
    bus.din_valid = 1'b0;
  endtask

  task automatic send_n(input int v, input int cnt);
    for (int i = 0; i < cnt; i++) send(v);
  endtask

  task automatic idle(input int cycles);
    repeat (cycles) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst            = 1'b0;
    clr            = 1'b0;
    bus.din_valid  = 1'b0;
    bus.din        = '0;
    bus.dout_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_dout_valid", int'(bus.dout_valid), 0);
    chk("rst_dout_sum", int'(bus.dout_sum), 0);
    chk("rst_dout_mean", int'(bus.dout_mean), 0);
    chk("rst_dout_ovf", int'(bus.dout_ovf), 0);
    rst = 1'b1;
    idle(1);

    // Basic windows, saturation and floor mean.
    send_n(100, 8);
    send_n(-32768, 8);
    send_n(32767, 8);
    send(-1);
    send_n(0, 7);
    idle(2);

    // Consumer stall followed by a queued window.
    bus.dout_ready = 1'b0;
    fork
      begin
        send_n(1, 8);
        send_n(2, 8);
      end
      begin
        int n;
        n = 0;
        while (!m_pend && n < 100) begin
          @(posedge clk);
          #1;
          n++;
        end
        if (!m_pend) chk("stall_wait_timeout", 0, 1);
        idle(5);
        bus.dout_ready = 1'b1;
      end
    join
    idle(2);

    // Clear mid-window discards the partial sum and the clear-cycle sample.
    send_n(7, 3);
    clr           = 1'b1;
    bus.din_valid = 1'b1;
    bus.din       = 16'sd99;
    idle(1);
    clr           = 1'b0;
    bus.din_valid = 1'b0;
    send_n(5, 8);
    idle(2);

    // Clear while a result is pending.
    bus.dout_ready = 1'b0;
    send_n(4, 8);
    clr = 1'b1;
    idle(1);
    clr = 1'b0;
    bus.dout_ready = 1'b1;
    send_n(6, 8);
    idle(2);

    // Asynchronous reset mid-window.
    send_n(11, 3);
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    chk("arst_win_valid", int'(bus.dout_valid), 0);
    rst = 1'b1;
    idle(1);

    // Asynchronous reset while a result is pending.
    bus.dout_ready = 1'b0;
    send_n(9, 8);
    chk("pend_before_arst", int'(m_pend), 1);
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    chk("arst_pend_valid", int'(bus.dout_valid), 0);
    chk("arst_pend_sum", int'(bus.dout_sum), 0);
    chk("arst_pend_mean", int'(bus.dout_mean), 0);
    rst = 1'b1;
    bus.dout_ready = 1'b1;
    idle(1);
    send_n(3, 8);
    idle(2);

    // Randomized traffic: bursty valid, stalling consumer, occasional clear.
    for (int i = 0; i < 1500; i++) begin
      int sel;
      sel            = $urandom_range(0, 7);
      clr            = ($urandom_range(0, 39) == 0);
      bus.din_valid  = ($urandom_range(0, 3) != 0);
      bus.dout_ready = ($urandom_range(0, 3) != 0);
      if (sel == 0)      bus.din = 16'sh7FFF;
      else if (sel == 1) bus.din = 16'sh8000;
      else               bus.din = DW'($urandom);
      idle(1);
    end
    clr           = 1'b0;
    bus.din_valid = 1'b0;
    bus.dout_ready = 1'b1;
    idle(4);
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
